// File: rtl/kyber_pkg.sv
// Shared Kyber constants, FSM encoding and modular helper for the NTT-domain basemul slice.
package kyber_pkg;

  localparam int unsigned KYBER_Q          = 3329;
  localparam int unsigned KYBER_N          = 256;
  localparam int unsigned BARRETT_V        = 5039;
  localparam int unsigned BARRETT_SHIFT    = 24;
  localparam int unsigned COEF_BITS        = 12;
  localparam int unsigned PROD_BITS        = 24;
  localparam int unsigned NUM_PAIRS        = KYBER_N / 2;

  localparam int unsigned WIDTH            = 16;
  localparam int unsigned WIDTH_ADDR       = 8;
  localparam int unsigned WIDTH_ADDR_GAMMA = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sum of three canonical residues (< 3q) folded back to [0,q) with two conditional subtracts.
  function automatic logic [COEF_BITS-1:0] mod_add3(input logic [COEF_BITS-1:0] x,
                                                    input logic [COEF_BITS-1:0] y,
                                                    input logic [COEF_BITS-1:0] z);
    logic [COEF_BITS+1:0] s;
    s = 14'(x) + 14'(y) + 14'(z);
    if (s >= 14'(2 * KYBER_Q))
      s = s - 14'(2 * KYBER_Q);
    else if (s >= 14'(KYBER_Q))
      s = s - 14'(KYBER_Q);
    return COEF_BITS'(s);
  endfunction

endpackage

// File: rtl/ntt_basemul_if.sv
// Control, source-read, gamma-ROM and destination-write bundle of ntt_basemul.
// NTT_BASEMUL_ACC_EN adds the accumulate request and the destination read-back data.
interface ntt_basemul_if;
  import kyber_pkg::*;

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        src_ren;
  logic [WIDTH_ADDR-1:0]       src_raddr_even;
  logic [WIDTH_ADDR-1:0]       src_raddr_odd;
  logic [WIDTH-1:0]            a_even;
  logic [WIDTH-1:0]            a_odd;
  logic [WIDTH-1:0]            b_even;
  logic [WIDTH-1:0]            b_odd;
  logic [WIDTH_ADDR_GAMMA-1:0] gamma_addr;
  logic [WIDTH-1:0]            gamma_in;
  logic                        wr_en;
  logic [WIDTH_ADDR-1:0]       wr_addr_even;
  logic [WIDTH_ADDR-1:0]       wr_addr_odd;
  logic [WIDTH-1:0]            wr_data_even;
  logic [WIDTH-1:0]            wr_data_odd;
`ifdef NTT_BASEMUL_ACC_EN
  logic                        accumulate;
  logic [WIDTH-1:0]            acc_even;
  logic [WIDTH-1:0]            acc_odd;
`endif

  modport master (
    input  start, a_even, a_odd, b_even, b_odd, gamma_in,
`ifdef NTT_BASEMUL_ACC_EN
    input  accumulate, acc_even, acc_odd,
`endif
    output busy, done, src_ren, src_raddr_even, src_raddr_odd, gamma_addr,
    output wr_en, wr_addr_even, wr_addr_odd, wr_data_even, wr_data_odd
  );

  modport slave (
    output start, a_even, a_odd, b_even, b_odd, gamma_in,
`ifdef NTT_BASEMUL_ACC_EN
    output accumulate, acc_even, acc_odd,
`endif
    input  busy, done, src_ren, src_raddr_even, src_raddr_odd, gamma_addr,
    input  wr_en, wr_addr_even, wr_addr_odd, wr_data_even, wr_data_odd
  );

endinterface

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 24-bit product to a canonical residue mod q.
module barrett_reduce
  import kyber_pkg::*;
(
  input  logic [PROD_BITS-1:0] x,
  output logic [COEF_BITS-1:0] r
);

  localparam int unsigned PW = PROD_BITS + 14;

  logic [13:0]          t;
  logic [PROD_BITS-1:0] tq;
  logic [PROD_BITS-1:0] diff;

  // Quotient estimate undershoots by at most one q, so a single correction is enough.
  always_comb begin
    t    = 14'((PW'(x) * PW'(BARRETT_V)) >> BARRETT_SHIFT);
    tq   = PROD_BITS'(t) * PROD_BITS'(KYBER_Q);
    diff = x - tq;
    r    = (diff >= PROD_BITS'(KYBER_Q)) ? COEF_BITS'(diff - PROD_BITS'(KYBER_Q))
                                         : COEF_BITS'(diff);
  end

endmodule

// File: rtl/ntt_basemul.sv
// Pointwise NTT-domain multiplier: 128 degree-1 products mod (X^2 - gamma_i), 6-cycle pipeline.
// Optional NTT_BASEMUL_ACC_EN adds the result onto the destination contents (inner products).
module ntt_basemul
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ntt_basemul_if.master bus
);

  state_t                      state;
  logic [WIDTH_ADDR_GAMMA-1:0] cnt;
  logic [WIDTH_ADDR_GAMMA-1:0] cnt_inc;
  logic [4:0]                  vld;
  logic [WIDTH_ADDR_GAMMA-1:0] idx_p [5];

  logic [PROD_BITS-1:0] p00_2, p01_2, p10_2, p11_2, m_4;
  logic [COEF_BITS-1:0] g2, g3;
  logic [COEF_BITS-1:0] r00_c, r01_c, r10_c, r11_c, rm_c;
  logic [COEF_BITS-1:0] r00_3, r01_3, r10_3, r11_3;
  logic [COEF_BITS-1:0] r00_4, c1_4;
  logic [COEF_BITS-1:0] r00_5, rm_5, c1_5;
  logic [COEF_BITS-1:0] acc0_5, acc1_5;
  logic [COEF_BITS-1:0] c0_6, c1_6;

  assign cnt_inc = cnt + WIDTH_ADDR_GAMMA'(1);

  barrett_reduce u_red00 (.x(p00_2), .r(r00_c));
  barrett_reduce u_red01 (.x(p01_2), .r(r01_c));
  barrett_reduce u_red10 (.x(p10_2), .r(r10_c));
  barrett_reduce u_red11 (.x(p11_2), .r(r11_c));
  barrett_reduce u_redm  (.x(m_4),   .r(rm_c));

`ifdef NTT_BASEMUL_ACC_EN
  logic                 acc_mode;
  logic [COEF_BITS-1:0] acc0_p [4];
  logic [COEF_BITS-1:0] acc1_p [4];

  // Destination read-back travels alongside its pair; zeroed when not accumulating.
  always_ff @(posedge clk) begin
    acc0_p[0] <= acc_mode ? COEF_BITS'(bus.acc_even) : COEF_BITS'(0);
    acc1_p[0] <= acc_mode ? COEF_BITS'(bus.acc_odd)  : COEF_BITS'(0);
    for (int k = 1; k < 4; k++) begin
      acc0_p[k] <= acc0_p[k-1];
      acc1_p[k] <= acc1_p[k-1];
    end
  end

  assign acc0_5 = acc0_p[3];
  assign acc1_5 = acc1_p[3];
`else
  assign acc0_5 = COEF_BITS'(0);
  assign acc1_5 = COEF_BITS'(0);
`endif

  assign c0_6 = mod_add3(r00_5, rm_5, acc0_5);
  assign c1_6 = mod_add3(c1_5, acc1_5, COEF_BITS'(0));

  // Datapath stages E2..E5; the memory output registers serve as E1.
  always_ff @(posedge clk) begin
    idx_p[0] <= bus.gamma_addr;
    for (int k = 1; k < 5; k++) idx_p[k] <= idx_p[k-1];

    p00_2 <= PROD_BITS'(32'(bus.a_even) * 32'(bus.b_even));
    p01_2 <= PROD_BITS'(32'(bus.a_even) * 32'(bus.b_odd));
    p10_2 <= PROD_BITS'(32'(bus.a_odd)  * 32'(bus.b_even));
    p11_2 <= PROD_BITS'(32'(bus.a_odd)  * 32'(bus.b_odd));
    g2    <= COEF_BITS'(bus.gamma_in);

    r00_3 <= r00_c;
    r01_3 <= r01_c;
    r10_3 <= r10_c;
    r11_3 <= r11_c;
    g3    <= g2;

    r00_4 <= r00_3;
    c1_4  <= mod_add3(r01_3, r10_3, COEF_BITS'(0));
    m_4   <= PROD_BITS'(r11_3) * PROD_BITS'(g3);

    r00_5 <= r00_4;
    c1_5  <= c1_4;
    rm_5  <= rm_c;
  end

  // Sequencer, valid chain and registered output stage E6.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      vld                <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.src_ren        <= 1'b0;
      bus.src_raddr_even <= '0;
      bus.src_raddr_odd  <= '0;
      bus.gamma_addr     <= '0;
      bus.wr_en          <= 1'b0;
      bus.wr_addr_even   <= '0;
      bus.wr_addr_odd    <= '0;
      bus.wr_data_even   <= '0;
      bus.wr_data_odd    <= '0;
`ifdef NTT_BASEMUL_ACC_EN
      acc_mode           <= 1'b0;
`endif
    end else begin
      bus.done  <= 1'b0;
      vld       <= {vld[3:0], bus.src_ren};
      bus.wr_en <= vld[4];
      if (vld[4]) begin
        bus.wr_addr_even <= {idx_p[4], 1'b0};
        bus.wr_addr_odd  <= {idx_p[4], 1'b1};
        bus.wr_data_even <= WIDTH'(c0_6);
        bus.wr_data_odd  <= WIDTH'(c1_6);
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state              <= RUN;
            cnt                <= '0;
            bus.busy           <= 1'b1;
            bus.src_ren        <= 1'b1;
            bus.src_raddr_even <= WIDTH_ADDR'(0);
            bus.src_raddr_odd  <= WIDTH_ADDR'(1);
            bus.gamma_addr     <= '0;
`ifdef NTT_BASEMUL_ACC_EN
            acc_mode           <= bus.accumulate;
`endif
          end
        end
        RUN: begin
          if (cnt == WIDTH_ADDR_GAMMA'(NUM_PAIRS - 1)) begin
            state       <= DRAIN;
            bus.src_ren <= 1'b0;
          end else begin
            cnt                <= cnt_inc;
            bus.src_raddr_even <= {cnt_inc, 1'b0};
            bus.src_raddr_odd  <= {cnt_inc, 1'b1};
            bus.gamma_addr     <= cnt_inc;
          end
        end
        DRAIN: begin
          if (vld == 5'd0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_basemul.sv
// Randomized self-checking bench for ntt_basemul against a plain-arithmetic pointwise model.
module tb_ntt_basemul;

  localparam int Q = 3329;

  logic clk = 1'b0;
  logic rst_n;

  ntt_basemul_if bus();

  ntt_basemul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int a_mem   [256];
  int b_mem   [256];
  int g_rom   [128];
  int acc_mem [256];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Source BRAMs and gamma ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.src_ren) begin
      bus.a_even <= 16'(a_mem[bus.src_raddr_even]);
      bus.a_odd  <= 16'(a_mem[bus.src_raddr_odd]);
      bus.b_even <= 16'(b_mem[bus.src_raddr_even]);
      bus.b_odd  <= 16'(b_mem[bus.src_raddr_odd]);
`ifdef NTT_BASEMUL_ACC_EN
      bus.acc_even <= 16'(acc_mem[bus.src_raddr_even]);
      bus.acc_odd  <= 16'(acc_mem[bus.src_raddr_odd]);
`endif
    end
    bus.gamma_in <= 16'(g_rom[bus.gamma_addr]);
  end

  // (a0 + a1 X)(b0 + b1 X) mod (X^2 - g), optionally added to the existing destination pair.
  function automatic int ref_c0(input int i, input bit acc);
    longint s;
    s = longint'(a_mem[2*i]) * b_mem[2*i]
      + ((longint'(a_mem[2*i+1]) * b_mem[2*i+1]) % Q) * g_rom[i];
    if (acc) s += acc_mem[2*i];
    return int'(s % Q);
  endfunction

  function automatic int ref_c1(input int i, input bit acc);
    longint s;
    s = longint'(a_mem[2*i]) * b_mem[2*i+1] + longint'(a_mem[2*i+1]) * b_mem[2*i];
    if (acc) s += acc_mem[2*i+1];
    return int'(s % Q);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0: begin a_mem[2*i] = 1;    a_mem[2*i+1] = 1;    b_mem[2*i] = 1;    b_mem[2*i+1] = 1;    g_rom[i] = 1;    end
        1: begin a_mem[2*i] = 3328; a_mem[2*i+1] = 3328; b_mem[2*i] = 3328; b_mem[2*i+1] = 3328; g_rom[i] = 17;   end
        2: begin a_mem[2*i] = 2;    a_mem[2*i+1] = 3;    b_mem[2*i] = 5;    b_mem[2*i+1] = 7;    g_rom[i] = 3312; end
        default: begin
          a_mem[2*i]   = int'($urandom_range(Q - 1, 0));
          a_mem[2*i+1] = int'($urandom_range(Q - 1, 0));
          b_mem[2*i]   = int'($urandom_range(Q - 1, 0));
          b_mem[2*i+1] = int'($urandom_range(Q - 1, 0));
          g_rom[i]     = int'($urandom_range(Q - 1, 0));
        end
      endcase
      if (mode < 3) begin
        acc_mem[2*i]   = 3000;
        acc_mem[2*i+1] = 3328;
      end else begin
        acc_mem[2*i]   = int'($urandom_range(Q - 1, 0));
        acc_mem[2*i+1] = int'($urandom_range(Q - 1, 0));
      end
    end
  endtask

  // Cycle 0 is the cycle in which start is high; each loop step samples at the falling edge.
  task automatic run_op(input string name, input bit acc, input bit extra, input int rst_at);
    int writes = 0;
    int dones  = 0;
    int idx;
    @(negedge clk);
    check($sformatf("%s busy@0", name), 32'(bus.busy), 0);
    bus.start = 1'b1;
`ifdef NTT_BASEMUL_ACC_EN
    bus.accumulate = acc;
`endif
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      bus.start = extra && (n == 40 || n == 135);
      check($sformatf("%s busy@%0d", name, n),  32'(bus.busy),  (n <= 135) ? 1 : 0);
      check($sformatf("%s done@%0d", name, n),  32'(bus.done),  (n == 135) ? 1 : 0);
      check($sformatf("%s wr_en@%0d", name, n), 32'(bus.wr_en), (n >= 7 && n <= 134) ? 1 : 0);
      if (bus.done) dones++;
      if (bus.wr_en && n >= 7 && n <= 134) begin
        idx = n - 7;
        writes++;
        check($sformatf("%s addr_even[%0d]", name, idx), 32'(bus.wr_addr_even), 2*idx);
        check($sformatf("%s addr_odd[%0d]", name, idx),  32'(bus.wr_addr_odd),  2*idx + 1);
        check($sformatf("%s c0[%0d]", name, idx), 32'(bus.wr_data_even), ref_c0(idx, acc));
        check($sformatf("%s c1[%0d]", name, idx), 32'(bus.wr_data_odd),  ref_c1(idx, acc));
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s rst wr_en", name), 32'(bus.wr_en), 0);
        check($sformatf("%s rst busy", name),  32'(bus.busy),  0);
        repeat (3) begin
          @(negedge clk);
          check($sformatf("%s rst hold wr_en", name), 32'(bus.wr_en), 0);
        end
        rst_n = 1'b1;
        return;
      end
    end
    check($sformatf("%s write count", name), writes, 128);
    check($sformatf("%s done count", name),  dones,  1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
`ifdef NTT_BASEMUL_ACC_EN
    bus.accumulate = 1'b0;
`endif
    #12;
    check("reset busy",       32'(bus.busy),           0);
    check("reset done",       32'(bus.done),           0);
    check("reset wr_en",      32'(bus.wr_en),          0);
    check("reset src_ren",    32'(bus.src_ren),        0);
    check("reset raddr_odd",  32'(bus.src_raddr_odd),  0);
    check("reset gamma_addr", 32'(bus.gamma_addr),     0);
    check("reset wr_addr",    32'(bus.wr_addr_odd),    0);
    check("reset wr_data",    32'(bus.wr_data_even),   0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(0); run_op("ones",    1'b0, 1'b0, 0);
    fill(1); run_op("max",     1'b0, 1'b0, 0);
    fill(2); run_op("neg17",   1'b0, 1'b0, 0);
    check("neg17 model c0", ref_c0(5, 1'b0), 2982);
    fill(3); run_op("extra",   1'b0, 1'b1, 0);
    fill(3); run_op("rst",     1'b0, 1'b0, 50);
    fill(3); run_op("restart", 1'b0, 1'b0, 0);
`ifdef NTT_BASEMUL_ACC_EN
    fill(2); run_op("acc",     1'b1, 1'b0, 0);
    check("acc model c0", ref_c0(9, 1'b1), 2653);
    fill(3); run_op("accrand", 1'b1, 1'b0, 0);
    fill(3); run_op("noacc",   1'b0, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_basemul.md
Name: ntt_basemul

Overview:
- Pointwise multiplier for the NTT domain. Sits directly downstream of the NTT/INTT core and consumes two polynomials that the core has left in NTT form.
- For each pair index i = 0..127 it computes the degree-1 product mod (X^2 - gamma_i) mod q, where q = 3329.
- Reads even/odd coefficient pairs from the source BRAMs, reads gamma_i from a ROM, and writes canonical results into a destination BRAM.

Parameters:
- WIDTH, 16, coefficient bus width; the upper 4 bits are zero on output.
- WIDTH_ADDR, 8, coefficient address width for 256 entries.
- WIDTH_ADDR_GAMMA, 7, gamma ROM address width for 128 entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from RUN until DONE inclusive
- done  out  1  one-cycle pulse in DONE
- src_raddr_even  out  WIDTH_ADDR  2i, shared by the A and B source memories
- src_raddr_odd  out  WIDTH_ADDR  2i+1
- src_ren  out  1  read enable
- a_even, a_odd, b_even, b_odd  in  WIDTH each  source data; 1-cycle read latency; values in [0,q)
- gamma_addr  out  WIDTH_ADDR_GAMMA  i
- gamma_in  in  WIDTH  gamma_i stored canonical in [0,q), so -z is stored as q-z; 1-cycle latency
- wr_en  out  1  destination write strobe
- wr_addr_even, wr_addr_odd  out  WIDTH_ADDR  2i, 2i+1
- wr_data_even, wr_data_odd  out  WIDTH  c0, c1

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; pair counter 0; all pipeline valid bits 0.
- FSM states:
  - IDLE: start=1 -> RUN.
  - RUN: issues pair i each cycle; src_ren=1; addresses driven from the registered counter. After i=127 -> DRAIN.
  - DRAIN: waits until the pipeline valid chain is empty -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- start is ignored outside IDLE. A start that arrives in the same cycle as DONE is ignored.
- Arithmetic, for a0=a[2i], a1=a[2i+1], b0, b1, g=gamma_i:
  - c0 = (a0*b0 + ((a1*b1 mod q)*g)) mod q
  - c1 = (a0*b1 + a1*b0) mod q
- Pipeline, with issue at E0:
  - E1: register operands and g.
  - E2: register the four 24-bit products.
  - E3: Barrett-reduce each product to [0,q).
  - E4: c1 = sum of the two cross terms with one conditional subtract; m = r11*g.
  - E5: reduce m.
  - E6: c0 = r00 + m with one conditional subtract; wr_en=1.
- Latency: exactly 6 cycles from issue to write. Throughput: 1 pair/cycle. No stall.
- Barrett reduction: x < 2^24, V = 5039. t = (x*V)>>24; r = x - t*q; if r >= q then r -= q. The result is canonical.
- Timing from start sampled at cycle 0:
  - issues at cycles 1..128
  - wr_en high at cycles 7..134 (exactly 128 writes)
  - done at cycle 135
  - back in IDLE at cycle 136
- Reset mid-operation: wr_en and busy drop immediately and asynchronously; no further writes occur. A later start recomputes all 128 pairs.
- Hazard: source and destination may be the same BRAM. Pair i is read 6 cycles before it is written and each pair is touched once, so there is no read-after-write conflict.

Optional Feature:
- Macro: NTT_BASEMUL_ACC_EN.
- Defined:
  - Adds ports `accumulate` (in, 1, sampled with start) and acc_even/acc_odd (in, WIDTH, read from the destination memory at src addresses, 1-cycle latency).
  - When accumulate=1, E6 outputs (c0+acc_even) mod q and (c1+acc_odd) mod q using two conditional subtracts (sum < 3q).
  - Latency is unchanged.
  - Used for matrix-vector inner products.
- Undefined: no extra ports; results are overwritten, not accumulated.

Decomposition:
- Package kyber_pkg holds:
  - constants KYBER_Q=3329, KYBER_N=256, BARRETT_V=5039, BARRETT_SHIFT=24, COEF_BITS=12
  - FSM state encoding IDLE/RUN/DRAIN/DONE.
- Sub-module barrett_reduce: combinational, 24-bit in -> 12-bit canonical out. Instantiated 5 times (4 products plus m).

Test Plan:
- All a=1, b=1, gamma=1 -> every c0=2, c1=2; 128 wr_en pulses at cycles 7..134; done at cycle 135 only.
- a0=a1=b0=b1=3328, gamma=17 for all i -> c0=18, c1=2 everywhere.
- a0=2, a1=3, b0=5, b1=7, gamma=3312 (i.e. -17) -> c0=2982, c1=29; wr_addr_even/odd = 2i/2i+1 for i=0..127 in order.
- Extra start pulses at cycles 40 and 135 -> ignored; exactly one done; busy continuous cycles 1..135.
- rst_n low at cycle 50 -> wr_en=0 and busy=0 asynchronously. Restart -> full correct 128-pair result matching a software model on random inputs in [0,q).
- With NTT_BASEMUL_ACC_EN, accumulate=1, acc_even=3000, acc_odd=3328, operands as in case 3 -> c0=2653, c1=28.
